// File: rtl/gfx_scanout_reader.sv
// rtl/gfx_scanout_reader.sv - scanout read engine: graphics buffer prefetch and 1-bit pixel serialiser
//
// Sweeps the read port of the 16K x 8 graphics buffer one active line at a
// time, keeps at most two bytes ahead of the pixel stream (shift register,
// 2-entry byte buffer and reads in flight together), and shifts bytes out
// MSB-first as one pixel per pixel_en_i.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   frame_start_i        one-cycle frame start pulse (abort, restart at line 0)
//   line_start_i         one-cycle active-line fetch window start
//   pixel_en_i           consume one pixel this cycle
//   mem_addr_o/mem_ce_o  registered read address and one-cycle read strobe
//   mem_oce_o            buffer output-register enable, 1 from first clock
//   mem_dout_i           read data, valid RD_LATENCY cycles after mem_ce_o
//   pixel_out_o          registered pixel value
//   pixel_active_o       registered: pixel_out_o is an active-area pixel
//   underrun_o           sticky: pixel needed with no byte available
//   underrun_clr_i       clears underrun_o (a new underrun wins)
module gfx_scanout_reader #(
  parameter int unsigned H_BYTES    = 64,
  parameter int unsigned V_LINES    = 192,
  parameter logic [13:0] BASE_ADDR  = 14'h0000,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_start_i,
  input  logic        line_start_i,
  input  logic        pixel_en_i,
  output logic [13:0] mem_addr_o,
  output logic        mem_ce_o,
  output logic        mem_oce_o,
  input  logic [7:0]  mem_dout_i,
  output logic        pixel_out_o,
  output logic        pixel_active_o,
  output logic        underrun_o,
  input  logic        underrun_clr_i
);

  localparam int unsigned LW = $clog2(V_LINES + 1);
  localparam int unsigned BW = $clog2(H_BYTES + 1);
  localparam int unsigned PW = $clog2(H_BYTES * 8 + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         line_cnt_q, line_cnt_d;
  logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [13:0]           mem_addr_q, mem_addr_d;
  logic                  mem_ce_q;
  logic                  oce_q;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [1:0][7:0]       fifo_q, fifo_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [7:0]            sr_q, sr_d;
  logic [3:0]            sr_cnt_q, sr_cnt_d;
  logic                  pix_out_q, pix_act_q;
  logic                  underrun_q, underrun_d;

  logic                  pix_req, pix_ok, pix_under, capture;
  logic                  flush, start_line, issue;
  logic [BW-1:0]         issue_byte;
  logic [2:0]            occ;

  assign pix_req   = (state_q == ACTIVE) && pixel_en_i;
  assign pix_ok    = pix_req && (sr_cnt_q != 4'd0);
  assign pix_under = pix_req && (sr_cnt_q == 4'd0);
  assign capture   = vld_q[RD_LATENCY-1];

  // Bytes held or owed: shift register, buffer, strobe this cycle, tags in flight.
  // Counting the shift register keeps the fetch at most two bytes ahead.
  assign occ = {1'b0, fifo_cnt_q} + 3'(sr_cnt_q != 4'd0) + 3'(mem_ce_q)
             + 3'($countones(vld_q));

  assign underrun_d = pix_under | (underrun_q & ~underrun_clr_i);

  // Next-state, counters and read issue.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    mem_addr_d = mem_addr_q;
    flush      = 1'b0;
    start_line = 1'b0;
    issue      = 1'b0;
    issue_byte = byte_cnt_q;

    if (pix_req) begin
      pix_cnt_d = pix_cnt_q + PW'(1);
    end

    if (frame_start_i) begin
      flush      = 1'b1;
      line_cnt_d = '0;
      state_d    = WAIT_LINE;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        WAIT_LINE: begin
          if (line_start_i) begin
            start_line = 1'b1;
            state_d    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (line_start_i) begin
            flush      = 1'b1;
            line_cnt_d = line_cnt_q + LW'(1);
            if (line_cnt_d == LW'(V_LINES)) begin
              state_d = IDLE;
            end else begin
              start_line = 1'b1;
            end
          end else if (pix_cnt_d == PW'(H_BYTES * 8)) begin
            flush      = 1'b1;
            line_cnt_d = line_cnt_q + LW'(1);
            state_d    = (line_cnt_d == LW'(V_LINES)) ? IDLE : WAIT_LINE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Byte 0 of a new line goes out on the start edge itself so the first
    // byte lands RD_LATENCY+1 cycles into ACTIVE.
    if (start_line) begin
      pix_cnt_d  = '0;
      issue      = 1'b1;
      issue_byte = '0;
    end else if ((state_q == ACTIVE) && (state_d == ACTIVE) && !flush &&
                 (occ < 3'd2) && (byte_cnt_q < BW'(H_BYTES))) begin
      issue = 1'b1;
    end

    if (issue) begin
      byte_cnt_d = issue_byte + BW'(1);
      mem_addr_d = BASE_ADDR + 14'(line_cnt_d) * 14'(H_BYTES) + 14'(issue_byte);
    end
  end

  // Return capture, byte buffer and shift register.
  always_comb begin
    sr_d       = sr_q;
    sr_cnt_d   = sr_cnt_q;
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    vld_d      = (vld_q << 1) | RD_LATENCY'(mem_ce_q);

    if (pix_ok) begin
      sr_d     = {sr_q[6:0], 1'b0};
      sr_cnt_d = sr_cnt_q - 4'd1;
    end

    // Reload when empty after this cycle's shift; a return with nothing
    // queued bypasses the buffer, otherwise it queues behind the head.
    if (sr_cnt_d == 4'd0) begin
      if (fifo_cnt_q != 2'd0) begin
        sr_d       = fifo_q[0];
        sr_cnt_d   = 4'd8;
        fifo_d[0]  = fifo_q[1];
        fifo_cnt_d = fifo_cnt_q - 2'd1;
        if (capture) begin
          fifo_d[fifo_cnt_d[0]] = mem_dout_i;
          fifo_cnt_d            = fifo_cnt_d + 2'd1;
        end
      end else if (capture) begin
        sr_d     = mem_dout_i;
        sr_cnt_d = 4'd8;
      end
    end else if (capture) begin
      fifo_d[fifo_cnt_q[0]] = mem_dout_i;
      fifo_cnt_d            = fifo_cnt_q + 2'd1;
    end

    // Clearing the tags (including the one entering from mem_ce_q) keeps
    // late data from the aborted line out of the new one.
    if (flush) begin
      sr_cnt_d   = '0;
      fifo_cnt_d = '0;
      vld_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      line_cnt_q <= '0;
      byte_cnt_q <= '0;
      pix_cnt_q  <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_ce_q   <= 1'b0;
      oce_q      <= 1'b0;
      vld_q      <= '0;
      fifo_q     <= '0;
      fifo_cnt_q <= '0;
      sr_q       <= '0;
      sr_cnt_q   <= '0;
      pix_out_q  <= 1'b0;
      pix_act_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_ce_q   <= issue;
      oce_q      <= 1'b1;
      vld_q      <= vld_d;
      fifo_q     <= fifo_d;
      fifo_cnt_q <= fifo_cnt_d;
      sr_q       <= sr_d;
      sr_cnt_q   <= sr_cnt_d;
      pix_out_q  <= pix_ok & sr_q[7];
      pix_act_q  <= pix_req;
      underrun_q <= underrun_d;
    end
  end

  assign mem_addr_o     = mem_addr_q;
  assign mem_ce_o       = mem_ce_q;
  assign mem_oce_o      = oce_q;
  assign pixel_out_o    = pix_out_q;
  assign pixel_active_o = pix_act_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_gfx_scanout_reader.sv
// tb/tb_gfx_scanout_reader.sv - directed bench for gfx_scanout_reader
module tb_gfx_scanout_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, line_start, pixel_en, underrun_clr;
  logic [13:0] mem_addr;
  logic        mem_ce, mem_oce;
  logic [7:0]  mem_dout;
  logic        pixel_out, pixel_active, underrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem [16384];
  logic [7:0]  rd1, rd2;
  logic [13:0] ce_addr_q [$];
  logic        pix_q [$];
  logic        und_seen;

  always #5 clk = ~clk;

  gfx_scanout_reader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_start_i  (frame_start),
    .line_start_i   (line_start),
    .pixel_en_i     (pixel_en),
    .mem_addr_o     (mem_addr),
    .mem_ce_o       (mem_ce),
    .mem_oce_o      (mem_oce),
    .mem_dout_i     (mem_dout),
    .pixel_out_o    (pixel_out),
    .pixel_active_o (pixel_active),
    .underrun_o     (underrun),
    .underrun_clr_i (underrun_clr)
  );

  // Two-stage pipelined buffer read port (output register always enabled).
  always @(posedge clk) begin
    if (mem_ce) rd1 <= mem[mem_addr];
    rd2 <= rd1;
  end
  assign mem_dout = rd2;

  always @(negedge clk) begin
    if (mem_ce === 1'b1) ce_addr_q.push_back(mem_addr);
    if (pixel_active === 1'b1) pix_q.push_back(pixel_out);
    if (underrun === 1'b1) und_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    ce_addr_q.delete();
    pix_q.delete();
    und_seen = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1; cyc(1); line_start = 1'b0;
  endtask

  // Line start, idle for nlow cycles, then 520 cycles of continuous pixel_en.
  task automatic run_line(input int nlow);
    pulse_line();
    cyc(nlow);
    pixel_en = 1'b1;
    cyc(520);
    pixel_en = 1'b0;
    cyc(4);
  endtask

  function automatic logic [31:0] ce_at(input int i);
    if (i >= 0 && i < ce_addr_q.size()) return 32'(ce_addr_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check_fetch(input string tag, input logic [13:0] first);
    int bad = 0;
    chk({tag, "_nce"}, ce_addr_q.size(), 64);
    for (int i = 0; i < ce_addr_q.size(); i++)
      if (ce_addr_q[i] !== first + 14'(i)) bad++;
    chk({tag, "_seq"}, bad, 0);
  endtask

  task automatic check_pixels(input string tag, input int line);
    int mism = 0;
    chk({tag, "_npix"}, pix_q.size(), 512);
    for (int i = 0; i < 512 && i < pix_q.size(); i++) begin
      logic [7:0] b;
      b = mem[14'(line * 64 + i / 8)];
      if (pix_q[i] !== b[7 - i % 8]) mism++;
    end
    chk({tag, "_pixbits"}, mism, 0);
  endtask

  initial begin
    bit found;
    for (int k = 0; k < 16384; k++) mem[k] = 8'(k);
    rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    pixel_en = 1'b0; underrun_clr = 1'b0;
    clear_mon();

    // Reset values
    cyc(2);
    chk("rst_ce", mem_ce, 0);
    chk("rst_addr", mem_addr, 14'h0000);
    chk("rst_oce", mem_oce, 0);
    chk("rst_pact", pixel_active, 0);
    chk("rst_pout", pixel_out, 0);
    chk("rst_und", underrun, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("oce_after_rst", mem_oce, 1);
    cyc(2);

    // Line 0 with prefetch, then continuous pixels
    pulse_frame();
    clear_mon();
    run_line(3);
    check_fetch("l0", 14'h0000);
    chk("l0_first", ce_at(0), 32'h0000);
    chk("l0_last", ce_at(63), 32'h003F);
    check_pixels("l0", 0);
    chk("l0_pix15", (pix_q.size() > 15) ? 32'(pix_q[15]) : 32'hFFFF_FFFF, 1);
    chk("l0_und", und_seen, 0);

    // Rest of the frame: lines 1..190 aborted early, line 191 fully read
    for (int n = 1; n <= 190; n++) begin
      pulse_line();
      cyc(3);
    end
    clear_mon();
    run_line(3);
    check_fetch("l191", 14'h2FC0);
    chk("l191_first", ce_at(0), 32'h2FC0);
    chk("l191_last", ce_at(63), 32'h2FFF);
    check_pixels("l191", 191);
    chk("l191_und", und_seen, 0);

    // 193rd line_start: back in IDLE, nothing happens
    clear_mon();
    pixel_en = 1'b1;
    pulse_line();
    cyc(10);
    pixel_en = 1'b0;
    chk("idle_nce", ce_addr_q.size(), 0);
    chk("idle_npix", pix_q.size(), 0);

    // Stalled pixel_en: prefetch stops at two bytes, then resumes cleanly
    pulse_frame();
    clear_mon();
    pulse_line();
    cyc(20);
    chk("stall_nce", ce_addr_q.size(), 2);
    pixel_en = 1'b1;
    cyc(520);
    pixel_en = 1'b0;
    cyc(4);
    check_fetch("stall", 14'h0000);
    check_pixels("stall", 0);
    chk("stall_und", und_seen, 0);

    // frame_start during line 5, byte 30 issue
    pulse_frame();
    clear_mon();
    for (int n = 0; n < 6; n++) begin
      pulse_line();
      cyc(3);
    end
    pixel_en = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 600 && !found; t++) begin
      cyc(1);
      if (mem_ce === 1'b1 && mem_addr === 14'h015E) found = 1'b1;
    end
    chk("fs_found_b30", found, 1);
    frame_start = 1'b1;
    pixel_en = 1'b0;
    cyc(1);
    frame_start = 1'b0;
    cyc(3);
    chk("fs_und_before", und_seen, 0);
    clear_mon();
    run_line(3);
    chk("fs_first", ce_at(0), 32'h0000);
    check_fetch("fs", 14'h0000);
    check_pixels("fs", 0);
    chk("fs_und", underrun, 0);

    // Underrun: pixel_en on the cycle after line_start
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
    line_start = 1'b1; cyc(1); line_start = 1'b0;
    pixel_en = 1'b1;
    cyc(1);
    chk("und_set", underrun, 1);
    chk("und_pout", pixel_out, 0);
    chk("und_pact", pixel_active, 1);
    underrun_clr = 1'b1;
    cyc(1);
    chk("und_clr_vs_set", underrun, 1);
    pixel_en = 1'b0;
    cyc(1);
    chk("und_cleared", underrun, 0);
    underrun_clr = 1'b0;

    // line_start mid-line: abort and restart on line 1
    clear_mon();
    cyc(2);
    line_start = 1'b1; cyc(1); line_start = 1'b0;
    pixel_en = 1'b1;
    cyc(3);
    chk("abort_first", ce_at(0), 32'h0040);
    chk("abort_second", ce_at(1), 32'h0041);
    chk("abort_und", underrun, 1);
    cyc(20);

    // Reset mid-ACTIVE
    rst_n = 1'b0;
    #1;
    chk("rst2_ce", mem_ce, 0);
    chk("rst2_pact", pixel_active, 0);
    chk("rst2_und", underrun, 0);
    chk("rst2_addr", mem_addr, 14'h0000);
    chk("rst2_oce", mem_oce, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    cyc(10);
    pixel_en = 1'b0;
    chk("rst2_idle_nce", ce_addr_q.size(), 0);
    chk("rst2_idle_npix", pix_q.size(), 0);
    chk("rst2_oce_after", mem_oce, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
